// File: rtl/lcd_spi_monitor.sv
// lcd_spi_monitor: passive LCD SPI sniffer decoding CASET/RASET/RAMWR into addressed pixel writes
module lcd_spi_monitor #(
  parameter int LCD_W = 132,
  parameter int LCD_H = 162
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_cs_n_in,
  input  logic        lcd_clk_in,
  input  logic        lcd_data_in,
  input  logic        lcd_dc_in,
  input  logic        lcd_rst_n_in,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_dc,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, CASET, RASET, RAMWR} state_t;
  state_t state, nxt;
  logic [1:0] cs_q, sck_q, d_q, dc_q, rn_q;
  logic sck_d, rise_q, srst, cmd, dat, tog, wrap_x, wrap_y, in_b;
  logic [2:0] bit_cnt;
  logic [7:0] sh, hi, xs, xe, ys, ye, cur_x, cur_y, nx_x, nx_y;
  logic [1:0] idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q  <= 2'b11;
      sck_q <= 2'b00;
      d_q   <= 2'b00;
      dc_q  <= 2'b00;
      rn_q  <= 2'b11;
      sck_d <= 1'b0;
    end else begin
      cs_q  <= {cs_q[0], lcd_cs_n_in};
      sck_q <= {sck_q[0], lcd_clk_in};
      d_q   <= {d_q[0], lcd_data_in};
      dc_q  <= {dc_q[0], lcd_dc_in};
      rn_q  <= {rn_q[0], lcd_rst_n_in};
      sck_d <= sck_q[1];
    end
  end
  assign srst = rst | ~rn_q[1];
  always_ff @(posedge clk) begin
    byte_valid <= 1'b0;
    if (srst) begin
      rise_q     <= 1'b0;
      sh         <= 8'd0;
      bit_cnt    <= 3'd0;
      byte_data  <= 8'd0;
      byte_is_dc <= 1'b0;
    end else begin
      rise_q <= sck_q[1] & ~sck_d;
      if (cs_q[1]) begin
        bit_cnt <= 3'd0;
      end else if (rise_q) begin
        sh      <= {sh[6:0], d_q[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data  <= {sh[6:0], d_q[1]};
          byte_is_dc <= dc_q[1];
          byte_valid <= 1'b1;
        end
      end
    end
  end
  assign cmd = byte_valid & ~byte_is_dc;
  assign dat = byte_valid & byte_is_dc;
  always_ff @(posedge clk) state <= srst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    if (cmd)
      nxt = byte_data == 8'h2A ? CASET : byte_data == 8'h2B ? RASET : byte_data == 8'h2C ? RAMWR : IDLE;
    else if (dat && (state == CASET || state == RASET) && idx == 2'd3)
      nxt = IDLE;
  end
  always_comb begin
    wrap_x = cur_x == xe;
    wrap_y = cur_y == ye;
    nx_x   = wrap_x ? xs : cur_x + 8'd1;
    nx_y   = wrap_x ? (wrap_y ? ys : cur_y + 8'd1) : cur_y;
    in_b   = ({24'd0, cur_x} < 32'(LCD_W)) && ({24'd0, cur_y} < 32'(LCD_H));
  end
  always_ff @(posedge clk) begin
    pix_we     <= 1'b0;
    frame_done <= 1'b0;
    if (srst) begin
      xs       <= 8'd0;
      xe       <= 8'(LCD_W - 1);
      ys       <= 8'd0;
      ye       <= 8'(LCD_H - 1);
      idx      <= 2'd0;
      tog      <= 1'b0;
      hi       <= 8'd0;
      cur_x    <= 8'd0;
      cur_y    <= 8'd0;
      pix_x    <= 8'd0;
      pix_y    <= 8'd0;
      pix_data <= 16'd0;
      err      <= 1'b0;
    end else if (cmd) begin
      idx <= 2'd0;
      tog <= 1'b0;
      if (byte_data == 8'h2C) begin
        cur_x <= xs;
        cur_y <= ys;
        if (xs > xe || ys > ye) err <= 1'b1;
      end
    end else if (dat && (state == CASET || state == RASET)) begin
      idx <= idx + 2'd1;
      if (!idx[0] && byte_data != 8'd0) err <= 1'b1;
      if (idx == 2'd1 && state == CASET) xs <= byte_data;
      if (idx == 2'd3 && state == CASET) xe <= byte_data;
      if (idx == 2'd1 && state == RASET) ys <= byte_data;
      if (idx == 2'd3 && state == RASET) ye <= byte_data;
    end else if (dat && state == RAMWR) begin
      tog <= ~tog;
      if (!tog) begin
        hi <= byte_data;
      end else begin
        cur_x      <= nx_x;
        cur_y      <= nx_y;
        frame_done <= wrap_x & wrap_y;
        if (in_b) begin
          pix_we   <= 1'b1;
          pix_x    <= cur_x;
          pix_y    <= cur_y;
          pix_data <= {hi, byte_data};
        end else begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_spi_monitor.sv
// tb_lcd_spi_monitor: directed-vector bench for lcd_spi_monitor
module tb_lcd_spi_monitor;
  logic clk = 0, rst = 1;
  logic lcd_cs_n_in = 1, lcd_clk_in = 0, lcd_data_in = 0, lcd_dc_in = 0, lcd_rst_n_in = 1;
  logic byte_valid, byte_is_dc, pix_we, frame_done, err;
  logic [7:0] byte_data, pix_x, pix_y;
  logic [15:0] pix_data;
  logic s_byte_valid, s_byte_is_dc, s_pix_we, s_frame_done, s_err;
  logic [7:0] s_byte_data, s_pix_x, s_pix_y;
  logic [15:0] s_pix_data;
  int n_chk = 0, n_bad = 0, cyc = 0, n_bytes = 0, bv_cyc = 0, rise_cyc = 0;
  logic [32:0] px_q[$], s_q[$];
  lcd_spi_monitor dut (
    .clk(clk), .rst(rst), .lcd_cs_n_in(lcd_cs_n_in), .lcd_clk_in(lcd_clk_in),
    .lcd_data_in(lcd_data_in), .lcd_dc_in(lcd_dc_in), .lcd_rst_n_in(lcd_rst_n_in),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_dc(byte_is_dc),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_done(frame_done), .err(err)
  );
  lcd_spi_monitor #(.LCD_W(6), .LCD_H(4)) sdut (
    .clk(clk), .rst(rst), .lcd_cs_n_in(lcd_cs_n_in), .lcd_clk_in(lcd_clk_in),
    .lcd_data_in(lcd_data_in), .lcd_dc_in(lcd_dc_in), .lcd_rst_n_in(lcd_rst_n_in),
    .byte_valid(s_byte_valid), .byte_data(s_byte_data), .byte_is_dc(s_byte_is_dc),
    .pix_we(s_pix_we), .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_data(s_pix_data),
    .frame_done(s_frame_done), .err(s_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (byte_valid) begin
      n_bytes++;
      bv_cyc = cyc;
    end
    if (pix_we) px_q.push_back({frame_done, pix_x, pix_y, pix_data});
    if (s_pix_we) s_q.push_back({s_frame_done, s_pix_x, s_pix_y, s_pix_data});
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b, input logic dc);
    @(negedge clk);
    lcd_data_in = b;
    lcd_dc_in = dc;
    repeat (3) @(negedge clk);
    lcd_clk_in = 1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    lcd_clk_in = 0;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
  endtask
  task automatic send_px(input logic [15:0] p);
    send_byte(p[15:8], 1);
    send_byte(p[7:0], 1);
  endtask
  task automatic settle();
    repeat (8) @(negedge clk);
  endtask
  task automatic do_rst();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int nb, np;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_bv", byte_valid, 0);
    check("rst_bd", byte_data, 0);
    check("rst_dc", byte_is_dc, 0);
    check("rst_we", pix_we, 0);
    check("rst_pxy", {pix_x, pix_y, pix_data}, 0);
    check("rst_fd", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_win", {dut.xs, dut.xe, dut.ys, dut.ye}, {8'd0, 8'd131, 8'd0, 8'd161});
    repeat (20) @(negedge clk);
    check("idle_nobytes", n_bytes, 0);
    lcd_cs_n_in = 0;
    repeat (4) @(negedge clk);
    send_byte(8'h2A, 0);
    settle();
    check("dec_cnt", n_bytes, 1);
    check("dec_data", byte_data, 8'h2A);
    check("dec_dc", byte_is_dc, 0);
    check("dec_lat", 64'(bv_cyc - rise_cyc), 4);
    send_byte(8'h2A, 0);
    send_byte(8'h00, 1); send_byte(8'h0A, 1); send_byte(8'h00, 1); send_byte(8'h0B, 1);
    send_byte(8'h2B, 0);
    send_byte(8'h00, 1); send_byte(8'h14, 1); send_byte(8'h00, 1); send_byte(8'h15, 1);
    send_byte(8'h2C, 0);
    send_px(16'hF800); send_px(16'h07E0); send_px(16'h001F); send_px(16'hFFFF);
    settle();
    check("win_cnt", px_q.size(), 4);
    check("win_p0", px_q[0], {1'b0, 8'd10, 8'd20, 16'hF800});
    check("win_p1", px_q[1], {1'b0, 8'd11, 8'd20, 16'h07E0});
    check("win_p2", px_q[2], {1'b0, 8'd10, 8'd21, 16'h001F});
    check("win_p3", px_q[3], {1'b1, 8'd11, 8'd21, 16'hFFFF});
    check("win_err", err, 0);
    nb = n_bytes;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    lcd_cs_n_in = 1;
    repeat (6) @(negedge clk);
    lcd_cs_n_in = 0;
    settle();
    check("part_nobyte", n_bytes, nb);
    send_byte(8'h2B, 0);
    settle();
    check("part_realign", {32'(n_bytes - nb), 24'd0, byte_data}, {32'd1, 24'd0, 8'h2B});
    np = px_q.size();
    send_byte(8'h2C, 0);
    send_byte(8'h12, 1);
    send_byte(8'h00, 0);
    settle();
    check("dangle_nopix", px_q.size(), np);
    check("dangle_idle", 64'(dut.state), 0);
    send_byte(8'h2A, 0);
    send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h05, 1);
    settle();
    check("hi_err", err, 1);
    check("hi_win", {dut.xs, dut.xe}, {8'd0, 8'd5});
    do_rst();
    check("rst2_err", err, 0);
    check("rst2_out", {pix_x, pix_y, pix_data, byte_data}, 0);
    np = px_q.size();
    send_byte(8'h2A, 0);
    send_byte(8'h00, 1); send_byte(8'h83, 1); send_byte(8'h00, 1); send_byte(8'h84, 1);
    send_byte(8'h2C, 0);
    send_px(16'h1234);
    settle();
    check("oob_in", px_q.size(), np + 1);
    check("oob_p0", px_q[np], {1'b0, 8'd131, 8'd0, 16'h1234});
    check("oob_noerr", err, 0);
    send_px(16'h5678);
    settle();
    check("oob_supp", px_q.size(), np + 1);
    check("oob_err", err, 1);
    @(negedge clk);
    lcd_rst_n_in = 0;
    repeat (6) @(negedge clk);
    lcd_rst_n_in = 1;
    repeat (4) @(negedge clk);
    check("soft_err", err, 0);
    check("soft_win", {dut.xs, dut.xe, dut.ys, dut.ye}, {8'd0, 8'd131, 8'd0, 8'd161});
    np = s_q.size();
    nb = px_q.size();
    send_byte(8'h2C, 0);
    for (int i = 1; i <= 25; i++) send_px(16'(i));
    settle();
    check("frm_cnt", s_q.size(), np + 25);
    check("frm_mid", s_q[np + 6], {1'b0, 8'd0, 8'd1, 16'd7});
    check("frm_last", s_q[np + 23], {1'b1, 8'd5, 8'd3, 16'd24});
    check("frm_wrap", s_q[np + 24], {1'b0, 8'd0, 8'd0, 16'd25});
    check("frm_prev", s_q[np + 22], {1'b0, 8'd4, 8'd3, 16'd23});
    check("frm_big", px_q[nb + 24], {1'b0, 8'd24, 8'd0, 16'd25});
    check("frm_err", s_err, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
